// File: rtl/trior_weak0_resolver_pkg.sv
// Shared constants and types for the trior/weak0 bus resolver.
package trior_pkg;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    WEAK0  = 1'b0,
    STRONG = 1'b1
  } strength_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/trior_weak0_resolver_if.sv
// Driver-side and consumer-side signals of the trior resolver.
interface trior_weak0_resolver_if #(
  parameter int unsigned NUM_DRV = 4,
  parameter int unsigned WIDTH   = 8
);
  import trior_pkg::*;

  logic                     in_valid;
  logic [NUM_DRV*WIDTH-1:0] drv_en;
  logic [NUM_DRV*WIDTH-1:0] drv_val;
  logic                     cnt_clr;
  logic                     out_valid;
  logic [WIDTH-1:0]         bus_q;
  logic [WIDTH-1:0]         strong_q;
  logic [WIDTH-1:0]         contention_q;
  logic [WIDTH-1:0]         contention_sticky;
  logic [CNT_W-1:0]         contention_cnt;

  modport master (
    output in_valid, drv_en, drv_val, cnt_clr,
    input  out_valid, bus_q, strong_q, contention_q, contention_sticky, contention_cnt
  );

  modport slave (
    input  in_valid, drv_en, drv_val, cnt_clr,
    output out_valid, bus_q, strong_q, contention_q, contention_sticky, contention_cnt
  );

endinterface

// File: rtl/trior_weak0_resolver_bit_resolve.sv
// Single-bit trior resolution across all drivers; undriven bits fall to weak 0.
module trior_bit_resolve
  import trior_pkg::*;
#(
  parameter int unsigned NUM_DRV = 4
) (
  input  logic [NUM_DRV-1:0] i_en,
  input  logic [NUM_DRV-1:0] i_val,
  output logic               o_one,
  output logic               o_zero,
  output logic               o_value,
  output strength_t          o_strong,
  output logic               o_contention
);

  assign o_one        = |(i_en & i_val);
  assign o_zero       = |(i_en & ~i_val);
  // A driven 1 always wins; otherwise the bit is 0, driven or pulled.
  assign o_value      = o_one;
  assign o_strong     = (o_one | o_zero) ? STRONG : WEAK0;
  assign o_contention = o_one & o_zero;

endmodule

// File: rtl/trior_weak0_resolver.sv
// Registered trior/weak0 resolver with per-bit contention flags, sticky bits and a
// saturating contention-cycle counter.
module trior_weak0_resolver
  import trior_pkg::*;
#(
  parameter int unsigned NUM_DRV = 4,
  parameter int unsigned WIDTH   = 8
) (
  input logic                    clk,
  input logic                    rst,
  trior_weak0_resolver_if.slave  bus
);

  logic [WIDTH-1:0] w_one;
  logic [WIDTH-1:0] w_zero;
  logic [WIDTH-1:0] w_value;
  logic [WIDTH-1:0] w_strong;
  logic [WIDTH-1:0] w_cont;
  logic             w_any_cont;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NUM_DRV-1:0] w_en;
    logic [NUM_DRV-1:0] w_val;
    strength_t          w_str;

    // Gather bit b of every driver's slice.
    for (genvar d = 0; d < NUM_DRV; d++) begin : g_drv
      assign w_en[d]  = bus.drv_en[d*WIDTH+b];
      assign w_val[d] = bus.drv_val[d*WIDTH+b];
    end

    trior_bit_resolve #(
      .NUM_DRV(NUM_DRV)
    ) u_resolve (
      .i_en        (w_en),
      .i_val       (w_val),
      .o_one       (w_one[b]),
      .o_zero      (w_zero[b]),
      .o_value     (w_value[b]),
      .o_strong    (w_str),
      .o_contention(w_cont[b])
    );

    assign w_strong[b] = (w_str == STRONG);
  end

  assign w_any_cont = |(w_one & w_zero);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_bus;
  logic [WIDTH-1:0] r_strong;
  logic [WIDTH-1:0] r_cont;
  logic [WIDTH-1:0] r_sticky;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sticky_d;
  logic [CNT_W-1:0] w_cnt_d;

  // A clear restarts accumulation from whatever the same-cycle sample contributes.
  always_comb begin
    w_sticky_d = r_sticky;
    w_cnt_d    = r_cnt;
    if (bus.cnt_clr) begin
      w_sticky_d = bus.in_valid ? w_cont : '0;
      w_cnt_d    = (bus.in_valid && w_any_cont) ? CNT_W'(1) : '0;
    end else if (bus.in_valid) begin
      w_sticky_d = r_sticky | w_cont;
      if (w_any_cont) begin
        w_cnt_d = sat_inc(r_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_bus       <= '0;
      r_strong    <= '0;
      r_cont      <= '0;
      r_sticky    <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_bus    <= w_value;
        r_strong <= w_strong;
        r_cont   <= w_cont;
      end
      r_sticky <= w_sticky_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign bus.out_valid         = r_out_valid;
  assign bus.bus_q             = r_bus;
  assign bus.strong_q          = r_strong;
  assign bus.contention_q      = r_cont;
  assign bus.contention_sticky = r_sticky;
  assign bus.contention_cnt    = r_cnt;

endmodule

// File: tb/tb_trior_weak0_resolver.sv
// Scoreboard bench: stimulus pushes hand-computed responses, a monitor pops on out_valid.
module tb_trior_weak0_resolver;
  localparam int unsigned NDRV = 4;
  localparam int unsigned W    = 8;

  typedef struct packed {
    logic [7:0]  bus;
    logic [7:0]  str;
    logic [7:0]  cont;
    logic [7:0]  sticky;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [7:0]  m_sticky = '0;
  logic [15:0] m_cnt    = '0;

  always #5 clk = ~clk;

  trior_weak0_resolver_if #(.NUM_DRV(NDRV), .WIDTH(W)) ifc ();

  trior_weak0_resolver #(
    .NUM_DRV(NDRV),
    .WIDTH  (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs settle after posedge, so sample on negedge.
  always @(negedge clk) begin
    exp_t e;
    if (ifc.out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending sample");
      end else begin
        e = sb.pop_front();
        chk("bus_q", 32'(ifc.bus_q), 32'(e.bus));
        chk("strong_q", 32'(ifc.strong_q), 32'(e.str));
        chk("contention_q", 32'(ifc.contention_q), 32'(e.cont));
        chk("contention_sticky", 32'(ifc.contention_sticky), 32'(e.sticky));
        chk("contention_cnt", 32'(ifc.contention_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic sample(input logic [31:0] en, input logic [31:0] val, input logic clr,
                        input logic [7:0] eb, input logic [7:0] es, input logic [7:0] ec);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.drv_en   = en;
    ifc.drv_val  = val;
    ifc.cnt_clr  = clr;
    if (clr) begin
      m_sticky = ec;
      m_cnt    = (ec != 0) ? 16'd1 : 16'd0;
    end else begin
      m_sticky = m_sticky | ec;
      if (ec != 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    sb.push_back('{bus: eb, str: es, cont: ec, sticky: m_sticky, cnt: m_cnt});
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.cnt_clr  = 1'b0;
  endtask

  task automatic clear_idle();
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.cnt_clr  = 1'b1;
    m_sticky = '0;
    m_cnt    = '0;
    @(negedge clk);
    ifc.cnt_clr = 1'b0;
    chk("clr_sticky", 32'(ifc.contention_sticky), 32'(m_sticky));
    chk("clr_cnt", 32'(ifc.contention_cnt), 32'(m_cnt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
    chk({tag, "_bus_q"}, 32'(ifc.bus_q), 32'd0);
    chk({tag, "_strong_q"}, 32'(ifc.strong_q), 32'd0);
    chk({tag, "_contention_q"}, 32'(ifc.contention_q), 32'd0);
    chk({tag, "_sticky"}, 32'(ifc.contention_sticky), 32'd0);
    chk({tag, "_cnt"}, 32'(ifc.contention_cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.in_valid = 1'b0;
    ifc.drv_en   = '0;
    ifc.drv_val  = '0;
    ifc.cnt_clr  = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Nothing enabled: garbage values must not leak through.
    sample(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 8'h00, 8'h00, 8'h00);
    // Driver 0 alone.
    sample(32'h0000_00FF, 32'hFFFF_FFA5, 1'b0, 8'hA5, 8'hFF, 8'h00);
    // Driver 0 = 0x0F, driver 1 = 0xF0: full contention.
    sample(32'h0000_FFFF, 32'h0000_F00F, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    // Driver 2 low nibble drives 0; upper-nibble values are don't-care.
    sample(32'h000F_0000, 32'h0000_0000, 1'b0, 8'h00, 8'h0F, 8'h00);
    sample(32'h000F_0000, 32'hFFF0_FFFF, 1'b0, 8'h00, 8'h0F, 8'h00);
    // Partial contention: d0 = 0x3C on all bits, d1 drives 0 on low nibble.
    sample(32'h0000_0FFF, 32'h0000_003C, 1'b0, 8'h3C, 8'hFF, 8'h0C);
    // All four drivers agree.
    sample(32'hFFFF_FFFF, 32'h8181_8181, 1'b0, 8'h81, 8'hFF, 8'h00);
    idle();
    idle();
    idle();
    chk("hold_bus_q", 32'(ifc.bus_q), 32'h81);
    chk("hold_sticky", 32'(ifc.contention_sticky), 32'(m_sticky));
    chk("hold_cnt", 32'(ifc.contention_cnt), 32'(m_cnt));

    clear_idle();

    // Clear coinciding with a contending sample.
    sample(32'h0000_FFFF, 32'h0000_F00F, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    sample(32'h0000_0FFF, 32'h0000_003C, 1'b1, 8'h3C, 8'hFF, 8'h0C);
    idle();

    // Saturation: drive the counter to 0xFFFF and one beyond.
    clear_idle();
    for (int i = 0; i < 65536; i++) begin
      sample(32'h0000_FFFF, 32'h0000_F00F, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    end
    idle();
    idle();
    chk("saturated_cnt", 32'(ifc.contention_cnt), 32'h0000_FFFF);

    // Reset between samples: the sample presented during reset is dropped.
    sample(32'h0000_00FF, 32'h0000_00A5, 1'b0, 8'hA5, 8'hFF, 8'h00);
    @(negedge clk);
    rst          = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.drv_en   = 32'h0000_FFFF;
    ifc.drv_val  = 32'h0000_5A5A;
    @(negedge clk);
    chk_all_zero("midreset");
    rst          = 1'b0;
    ifc.in_valid = 1'b0;
    m_sticky = '0;
    m_cnt    = '0;
    sample(32'h0000_00FF, 32'h0000_003C, 1'b0, 8'h3C, 8'hFF, 8'h00);
    idle();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trior_weak0_resolver.md
# trior_weak0_resolver

Registered resolver for a multi-driver wired-OR (trior) bus with a weak0 pull-down, in synthesizable two-signal form: each driver supplies per-bit enable/value pairs, and the block produces the resolved value and per-bit drive strength. It also flags and counts driver contention. It sits between the internal bus-master ports and the shared status/interrupt bus consumers.

## Interface
- `NUM_DRV`, default 4: number of drivers, 2..16.
- `WIDTH`, default 8: bus width in bits, 1..32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the driver inputs are sampled this cycle.
- `drv_en` input NUM_DRV*WIDTH: per-driver, per-bit drive enable. Driver d owns bits [d*WIDTH +: WIDTH]. A 0 means high-Z.
- `drv_val` input NUM_DRV*WIDTH: per-driver, per-bit drive value, same packing. Ignored where `drv_en` = 0.
- `cnt_clr` input 1: clears `contention_sticky` and `contention_cnt`.
- `out_valid` output 1: the resolved outputs were updated from an `in_valid` sample.
- `bus_q` output WIDTH: resolved bus value.
- `strong_q` output WIDTH: 1 = bit is actively driven; 0 = bit is held only by the weak0 pull.
- `contention_q` output WIDTH: 1 = drivers disagreed on this bit in the sampled cycle.
- `contention_sticky` output WIDTH: OR-accumulation of `contention_q` since the last clear.
- `contention_cnt` output 16: number of sampled cycles with any contention; saturates at 0xFFFF.

## Operation
Per bit b, over all drivers d:
- `one[b]` = OR over d of (en & val).
- `zero[b]` = OR over d of (en & ~val).
- Resolution follows trior: if `one[b]`, the bit is 1 (strong).
- Else if `zero[b]`, the bit is 0 (strong).
- Else the bit is 0 (weak0 pull), with strong = 0.
- Contention on a bit = `one[b] & zero[b]`. The 1 still wins; contention is only flagged, never an error.
- Any number of simultaneously enabled drivers is legal.
- `drv_val` on non-enabled bits has no effect on any output.
- On a cycle with `in_valid` = 1:
  - `bus_q`, `strong_q` and `contention_q` load the resolution of that cycle.
  - `contention_sticky` |= `contention_q` next.
  - `contention_cnt` increments by 1 if any contention bit is set, saturating at 0xFFFF.
- On a cycle with `in_valid` = 0: `bus_q`, `strong_q` and `contention_q` hold their values. The sticky and counter state does not change, except for `cnt_clr`.
- `cnt_clr` and a contending sample in the same cycle: the clear wins for the accumulated state. `contention_sticky` becomes that cycle's new contention bits, and `contention_cnt` becomes 1.
- Reset values: every output is 0, including `out_valid`, `bus_q`, `strong_q`, `contention_q`, `contention_sticky` and `contention_cnt`.
- Reset has priority over `in_valid` and `cnt_clr`.

## Timing
- All outputs are registered; latency is 1 cycle from an `in_valid` sample.
- `out_valid` = `in_valid` delayed one cycle. It is a pulse per sample, with no backpressure.
- Reset asserted mid-stream: the next edge zeroes all state, and any sample presented in that cycle is dropped.
- The first sample is accepted on the first edge where `rst` = 0.
- Combinational depth is one OR-reduction tree of NUM_DRV inputs per bit, plus the contention AND and the counter increment.

## Structure
- Package `trior_pkg`:
  - `CNT_W` = 16.
  - `CNT_MAX` = 16'hFFFF.
  - Typedef `strength_t`, encoding {`WEAK0` = 0, `STRONG` = 1}.
- Sub-module `trior_bit_resolve`: takes the NUM_DRV en/val vectors of one bit and produces one, zero, value, strong and contention. It is instantiated WIDTH times via generate.
- The top level holds the registers, the sticky logic and the saturating counter.

## Test plan
- Reset, then `in_valid` with every `drv_en` = 0 -> one cycle later `bus_q` = 0x00, `strong_q` = 0x00, `contention_q` = 0x00, `out_valid` = 1.
- Driver 0 drives 0xA5 on all bits, other drivers off -> `bus_q` = 0xA5, `strong_q` = 0xFF, no contention.
- Driver 0 drives 0x0F and driver 1 drives 0xF0, both enabled on all bits -> `bus_q` = 0xFF, `contention_q` = 0xFF, `contention_cnt` = 1.
- Driver 2 enables only bits [3:0] with value 0x0 -> `bus_q` = 0x00, `strong_q` = 0x0F; `drv_val` changes on bits [7:4] cause no output change.
- Contending samples, then `cnt_clr` with `in_valid` = 0 -> `contention_sticky` = 0 and `contention_cnt` = 0. Separately, force the counter to 0xFFFF, apply one more contention -> it stays 0xFFFF.
- Assert `rst` between two samples -> all outputs are 0 on the next cycle and the sample presented during reset never appears.
